wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Writeback-side driver of the 32x32 general-purpose register file's single write port. Merges in-order pipeline writebacks with out-of-order results from the long-latency multiply/divide unit. Buffers long results in a small FIFO. Tracks pending long-latency destinations in a 32-bit busy scoreboard that the decode stage uses for stall decisions. Sits between the WB stage / muldiv unit and the register file write inputs.

## Interface
- FIFO_DEPTH, 4: long-result buffer entries; power of two, >= 2
- clock__i  in  1  core clock, single domain
- reset__i  in  1  synchronous, active-high
- PipeValid__i  in  1  pipeline writeback request this cycle; always accepted
- PipeAddr__i  in  5  pipeline destination register
- PipeData__i  in  32  pipeline writeback data
- LongValid__i  in  1  muldiv result offered
- LongAddr__i  in  5  muldiv destination register
- LongData__i  in  32  muldiv result data
- LongReady__o  out  1  muldiv result accepted when LongValid__i && LongReady__o
- Reserve__i  in  1  decode issued a long op; mark destination busy
- ReserveAddr__i  in  5  register to mark busy
- Busy__o  out  32  per-register pending-long-write flags; bit 0 always 0
- RegWrite__o  out  1  register file write enable
- AddrRd__o  out  5  register file write address
- DataRd__o  out  32  register file write data

## Operation
- Clocking and reset: one clock; reset is synchronous and active-high (reset__i sampled on posedge clock__i).
- All state updates on posedge clock__i.
- Outputs RegWrite__o/AddrRd__o/DataRd__o are registered and held stable for the full cycle. This lets the register file capture them on its negedge.
- Arbitration, evaluated each cycle, in priority order:
  1. PipeValid__i: emit pipeline write next cycle.
  2. Else FIFO non-empty: pop head and emit it.
  3. Else LongValid__i && LongReady__o: bypass the FIFO and emit the long result directly.
  4. Else RegWrite__o = 0 next cycle.
- Long input push: an accepted long result is pushed into the FIFO unless it took the bypass path (case 3).
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- LongReady__o = !full, computed from registered occupancy.
  - When full, LongReady__o deasserts and the muldiv unit holds its offer.
- FIFO order is strict FIFO, with pointer wrap-around modulo FIFO_DEPTH.
- r0 handling:
  - Any selected request with address 0 consumes its slot but drives RegWrite__o = 0.
  - Reserve of r0 is ignored.
- Busy scoreboard:
  - Set: Reserve__i sets Busy__o[ReserveAddr__i].
  - Clear: a long-sourced write (FIFO pop or bypass) clears its bit on the same edge that loads the output register.
  - Pipeline-sourced writes never clear busy bits.
  - Simultaneous set and clear of the same bit: set wins.
- WAW ordering: decode must not issue a pipeline write to a busy register. If it does anyway, both writes are emitted in arbitration order and the pipeline write lands first.

## Timing
- Reset values: RegWrite__o=0, AddrRd__o=0, DataRd__o=0, Busy__o=0, LongReady__o=0, FIFO empty.
- LongReady__o=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation discards all FIFO contents and busy bits; no write is emitted in the following cycle.
- Latency:
  - Pipeline write: 1 cycle from PipeValid__i to RegWrite__o.
  - Bypassed long write: 1 cycle.
  - Buffered long write: 1 cycle after the pop cycle.
- Worst-case long-result wait is unbounded while PipeValid__i stays high. Starvation is accepted; the FIFO provides backpressure.
- Busy__o is registered and reflects a reserve or clear one cycle after the triggering edge.

## Structure
- Shared package wb_pkg:
  - typedef wb_req_t {addr[4:0], data[31:0]}
  - constant REG_ZERO = 5'd0
  - constant NUM_REGS = 32
- Sub-module wb_fifo: parameterized FIFO of wb_req_t with push/pop/full/empty and a registered count.
- Arbiter, output register and scoreboard live in the top module.

## Test plan
- Reset, then idle: all outputs 0; LongReady__o=1 the cycle after reset deasserts; Busy__o=0.
- Long-only: LongValid__i with r5 = 0x1234_5678 while pipeline idle -> bypass; next cycle RegWrite__o=1, AddrRd__o=5, DataRd__o=0x12345678.
- Priority: pipeline writes r3 on 6 consecutive cycles while long results to r8..r12 are offered -> FIFO fills after 4 accepts and LongReady__o drops. Then pipeline idles -> r8..r11 emitted in order, then r12.
- Scoreboard: Reserve__i r7 -> Busy__o[7]=1. Long write r7 emitted -> Busy__o[7]=0. A reserve of r7 on the same edge as the clear leaves Busy__o[7]=1.
- r0: pipeline write r0 = 0xFFFF_FFFF -> RegWrite__o stays 0. Reserve r0 -> Busy__o[0] stays 0.
- Reset mid-flight with 3 FIFO entries and Busy__o=0x0000_0180 -> everything cleared; no write emitted after reset.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register file writeback path.
package wb_pkg;

    localparam int          NUM_REGS = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // One register file write: destination and value.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of writeback requests used to park long-latency results
// while the pipeline owns the register file write port.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head_req,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign head_req = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // Storage write; data is not reset, only the pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Drives the register file write port: pipeline writebacks take priority,
// muldiv results are bypassed when possible and buffered otherwise, and a
// busy scoreboard tracks destinations of long ops still in flight.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock__i,
    input  logic        reset__i,
    input  logic        PipeValid__i,
    input  logic [4:0]  PipeAddr__i,
    input  logic [31:0] PipeData__i,
    input  logic        LongValid__i,
    input  logic [4:0]  LongAddr__i,
    input  logic [31:0] LongData__i,
    output logic        LongReady__o,
    input  logic        Reserve__i,
    input  logic [4:0]  ReserveAddr__i,
    output logic [31:0] Busy__o,
    output logic        RegWrite__o,
    output logic [4:0]  AddrRd__o,
    output logic [31:0] DataRd__o
);

    logic    ready_en;
    logic    fifo_full;
    logic    fifo_empty;
    wb_req_t fifo_head;
    wb_req_t long_req;

    logic    long_accept;
    logic    sel_pipe;
    logic    sel_pop;
    logic    sel_bypass;
    logic    sel_valid;
    logic    fifo_push;
    wb_req_t sel_req;

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_next;

    assign long_req.addr = LongAddr__i;
    assign long_req.data = LongData__i;

    // ready_en keeps LongReady low while in reset and through the reset edge.
    assign LongReady__o = ready_en & ~fifo_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clock__i),
        .rst      (reset__i),
        .push     (fifo_push),
        .push_req (long_req),
        .pop      (sel_pop),
        .head_req (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Enable long-result acceptance from the first edge after reset.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Priority select: pipeline, then buffered long result, then bypass.
    always_comb begin
        sel_pipe    = 1'b0;
        sel_pop     = 1'b0;
        sel_bypass  = 1'b0;
        sel_req     = fifo_head;
        long_accept = LongValid__i && LongReady__o;
        if (PipeValid__i) begin
            sel_pipe     = 1'b1;
            sel_req.addr = PipeAddr__i;
            sel_req.data = PipeData__i;
        end else if (!fifo_empty) begin
            sel_pop = 1'b1;
            sel_req = fifo_head;
        end else if (long_accept) begin
            sel_bypass = 1'b1;
            sel_req    = long_req;
        end
        sel_valid = sel_pipe | sel_pop | sel_bypass;
        fifo_push = long_accept && !sel_bypass;
    end

    // Scoreboard update: reserve sets, long-sourced write clears, set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (Reserve__i && (ReserveAddr__i != REG_ZERO)) begin
            set_mask = NUM_REGS'(1) << ReserveAddr__i;
        end
        if (sel_pop || sel_bypass) begin
            clr_mask = NUM_REGS'(1) << sel_req.addr;
        end
        busy_next    = (Busy__o & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            Busy__o <= '0;
        end else begin
            Busy__o <= busy_next;
        end
    end

    // Write port register; r0 consumes its slot but never writes.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            RegWrite__o <= 1'b0;
            AddrRd__o   <= '0;
            DataRd__o   <= '0;
        end else begin
            RegWrite__o <= sel_valid && (sel_req.addr != REG_ZERO);
            if (sel_valid) begin
                AddrRd__o <= sel_req.addr;
                DataRd__o <= sel_req.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a table of per-cycle vectors plus a
// hand-written mid-flight reset sequence.
module tb_wb_port_arbiter;

    logic        clock;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        long_valid;
    logic [4:0]  long_addr;
    logic [31:0] long_data;
    logic        long_ready;
    logic        reserve;
    logic [4:0]  reserve_addr;
    logic [31:0] busy;
    logic        reg_write;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        rv;
        logic [4:0]  ra;
        logic        ewr;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        erdy;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs[$];

    wb_port_arbiter #(
        .FIFO_DEPTH (4)
    ) dut (
        .clock__i       (clock),
        .reset__i       (reset),
        .PipeValid__i   (pipe_valid),
        .PipeAddr__i    (pipe_addr),
        .PipeData__i    (pipe_data),
        .LongValid__i   (long_valid),
        .LongAddr__i    (long_addr),
        .LongData__i    (long_data),
        .LongReady__o   (long_ready),
        .Reserve__i     (reserve),
        .ReserveAddr__i (reserve_addr),
        .Busy__o        (busy),
        .RegWrite__o    (reg_write),
        .AddrRd__o      (addr_rd),
        .DataRd__o      (data_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid   = 1'b0;
        pipe_addr    = '0;
        pipe_data    = '0;
        long_valid   = 1'b0;
        long_addr    = '0;
        long_data    = '0;
        reserve      = 1'b0;
        reserve_addr = '0;
    endtask

    task automatic add(input string nm,
                       input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic rv, input logic [4:0] ra,
                       input logic ewr, input logic [4:0] ea, input logic [31:0] ed,
                       input logic erdy, input logic [31:0] ebusy);
        vec_t v;
        v.name = nm;
        v.pv = pv; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.rv = rv; v.ra = ra;
        v.ewr = ewr; v.ea = ea; v.ed = ed;
        v.erdy = erdy; v.ebusy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string nm, input logic ewr, input logic [4:0] ea,
                                 input logic [31:0] ed, input logic erdy, input logic [31:0] ebusy);
        chk({nm, ".wr"}, {31'd0, reg_write}, {31'd0, ewr});
        if (ewr) begin
            chk({nm, ".addr"}, {27'd0, addr_rd}, {27'd0, ea});
            chk({nm, ".data"}, data_rd, ed);
        end
        chk({nm, ".ready"}, {31'd0, long_ready}, {31'd0, erdy});
        chk({nm, ".busy"}, busy, ebusy);
    endtask

    initial begin
        //   name    pv pa     pd            lv la     ld            rv ra    ewr ea     ed            rdy busy
        add("bypass", 1'b0, 5'd0, 32'h0,      1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd5, 32'h12345678, 1'b1, 32'h0);
        add("idle0",  1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0);
        // Pipeline r3 for six cycles while muldiv offers r8..r12.
        add("pri1",   1'b1, 5'd3, 32'h30,     1'b1, 5'd8,  32'h80,      1'b0, 5'd0, 1'b1, 5'd3, 32'h30,       1'b1, 32'h0);
        add("pri2",   1'b1, 5'd3, 32'h31,     1'b1, 5'd9,  32'h90,      1'b0, 5'd0, 1'b1, 5'd3, 32'h31,       1'b1, 32'h0);
        add("pri3",   1'b1, 5'd3, 32'h32,     1'b1, 5'd10, 32'hA0,      1'b0, 5'd0, 1'b1, 5'd3, 32'h32,       1'b1, 32'h0);
        add("pri4",   1'b1, 5'd3, 32'h33,     1'b1, 5'd11, 32'hB0,      1'b0, 5'd0, 1'b1, 5'd3, 32'h33,       1'b0, 32'h0);
        add("pri5",   1'b1, 5'd3, 32'h34,     1'b1, 5'd12, 32'hC0,      1'b0, 5'd0, 1'b1, 5'd3, 32'h34,       1'b0, 32'h0);
        add("pri6",   1'b1, 5'd3, 32'h35,     1'b1, 5'd12, 32'hC0,      1'b0, 5'd0, 1'b1, 5'd3, 32'h35,       1'b0, 32'h0);
        // Pipeline idle: drain in order; r12 is accepted once space opens.
        add("drn8",   1'b0, 5'd0, 32'h0,      1'b1, 5'd12, 32'hC0,      1'b0, 5'd0, 1'b1, 5'd8,  32'h80,      1'b1, 32'h0);
        add("drn9",   1'b0, 5'd0, 32'h0,      1'b1, 5'd12, 32'hC0,      1'b0, 5'd0, 1'b1, 5'd9,  32'h90,      1'b1, 32'h0);
        add("drn10",  1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b0, 5'd0, 1'b1, 5'd10, 32'hA0,      1'b1, 32'h0);
        add("drn11",  1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b0, 5'd0, 1'b1, 5'd11, 32'hB0,      1'b1, 32'h0);
        add("drn12",  1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b0, 5'd0, 1'b1, 5'd12, 32'hC0,      1'b1, 32'h0);
        add("idle1",  1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b0, 5'd0, 1'b0, 5'd0,  32'h0,       1'b1, 32'h0);
        // Scoreboard set / clear / set-wins.
        add("rsv7",   1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b1, 5'd7, 1'b0, 5'd0,  32'h0,       1'b1, 32'h80);
        add("clr7",   1'b0, 5'd0, 32'h0,      1'b1, 5'd7,  32'h77,      1'b0, 5'd0, 1'b1, 5'd7,  32'h77,      1'b1, 32'h0);
        add("rsv7b",  1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b1, 5'd7, 1'b0, 5'd0,  32'h0,       1'b1, 32'h80);
        add("setwin", 1'b0, 5'd0, 32'h0,      1'b1, 5'd7,  32'h78,      1'b1, 5'd7, 1'b1, 5'd7,  32'h78,      1'b1, 32'h80);
        add("clr7b",  1'b0, 5'd0, 32'h0,      1'b1, 5'd7,  32'h79,      1'b0, 5'd0, 1'b1, 5'd7,  32'h79,      1'b1, 32'h0);
        // Pipeline writes never clear busy bits.
        add("rsv9",   1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b1, 5'd9, 1'b0, 5'd0,  32'h0,       1'b1, 32'h200);
        add("pipe9",  1'b1, 5'd9, 32'h99,     1'b0, 5'd0,  32'h0,       1'b0, 5'd0, 1'b1, 5'd9,  32'h99,      1'b1, 32'h200);
        add("clr9",   1'b0, 5'd0, 32'h0,      1'b1, 5'd9,  32'h9A,      1'b0, 5'd0, 1'b1, 5'd9,  32'h9A,      1'b1, 32'h0);
        // r0 handling.
        add("pipe0",  1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd0,  32'h0,       1'b1, 32'h0);
        add("rsv0",   1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,       1'b1, 5'd0, 1'b0, 5'd0,  32'h0,       1'b1, 32'h0);
        add("long0",  1'b0, 5'd0, 32'h0,      1'b1, 5'd0,  32'h5,       1'b0, 5'd0, 1'b0, 5'd0,  32'h0,       1'b1, 32'h0);

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check_outputs("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        chk("reset.addr", {27'd0, addr_rd}, 32'h0);
        chk("reset.data", data_rd, 32'h0);

        reset = 1'b0;
        step();
        check_outputs("post_reset", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            pipe_valid   = vecs[i].pv;
            pipe_addr    = vecs[i].pa;
            pipe_data    = vecs[i].pd;
            long_valid   = vecs[i].lv;
            long_addr    = vecs[i].la;
            long_data    = vecs[i].ld;
            reserve      = vecs[i].rv;
            reserve_addr = vecs[i].ra;
            step();
            check_outputs(vecs[i].name, vecs[i].ewr, vecs[i].ea, vecs[i].ed,
                          vecs[i].erdy, vecs[i].ebusy);
        end

        // Mid-flight reset: three buffered long results, r7/r8 busy.
        idle_inputs();
        pipe_valid = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h40;
        long_valid = 1'b1; long_addr = 5'd7; long_data = 32'h70;
        reserve = 1'b1; reserve_addr = 5'd7;
        step();
        pipe_data = 32'h41; long_addr = 5'd8; long_data = 32'h81; reserve_addr = 5'd8;
        step();
        pipe_data = 32'h42; long_addr = 5'd9; long_data = 32'h92; reserve = 1'b0;
        step();
        check_outputs("mid_fill", 1'b1, 5'd3, 32'h42, 1'b1, 32'h180);

        idle_inputs();
        reset = 1'b1;
        step();
        check_outputs("mid_reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        reset = 1'b0;
        step();
        check_outputs("mid_after1", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0);
        step();
        check_outputs("mid_after2", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
